// File: rtl/reg_mem.sv
// -----------------------------------------------------------------------------
// reg_mem
//   General-purpose register file for the processor datapath: NUM_REGS
//   registers of DATA_W bits, two combinational read ports feeding the ALU
//   operands and one clocked write port committing the writeback result.
//
// Ports
//   clk        in   1        single clock, all state changes on rising edge
//   reset      in   1        synchronous active-low reset, clears every register
//   write      in   1        write enable for wR/dataIn, active-high
//   opA        in   ADDR_W   read address for operand_a
//   opB        in   ADDR_W   read address for operand_b
//   wR         in   ADDR_W   write address
//   dataIn     in   DATA_W   write data
//   operand_a  out  DATA_W   contents of register opA (0 when out of range)
//   operand_b  out  DATA_W   contents of register opB (0 when out of range)
// -----------------------------------------------------------------------------
module reg_mem #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 3,
  parameter int NUM_REGS = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              write,
  input  logic [ADDR_W-1:0] opA,
  input  logic [ADDR_W-1:0] opB,
  input  logic [ADDR_W-1:0] wR,
  input  logic [DATA_W-1:0] dataIn,
  output logic [DATA_W-1:0] operand_a,
  output logic [DATA_W-1:0] operand_b
);

  logic [DATA_W-1:0] regs [NUM_REGS];

  // Register storage. Reset wins over a write on the same edge. The write
  // decode compares wR against each register index, so an address beyond
  // NUM_REGS simply matches nothing and the write is dropped.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (write) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wR == ADDR_W'(i)) begin
          regs[i] <= dataIn;
        end
      end
    end
  end

  // Read muxes built as an AND-OR select over all registers: an address that
  // selects no register yields 0, and an unselected register (even one that
  // still holds X before the first reset) never reaches the outputs.
  // There is deliberately no write bypass.
  always_comb begin
    operand_a = '0;
    operand_b = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (opA == ADDR_W'(i)) begin
        operand_a = regs[i];
      end
      if (opB == ADDR_W'(i)) begin
        operand_b = regs[i];
      end
    end
  end

endmodule

// File: tb/tb_reg_mem.sv
// -----------------------------------------------------------------------------
// tb_reg_mem
//   Self-checking bench for reg_mem. A plain array model of the eight
//   registers is updated with the register-file rules (reset clears all,
//   write stores dataIn at wR) and every read is compared with it.
// -----------------------------------------------------------------------------
module tb_reg_mem;

  logic       clk;
  logic       reset;
  logic       write;
  logic [2:0] opA;
  logic [2:0] opB;
  logic [2:0] wR;
  logic [7:0] dataIn;
  logic [7:0] operand_a;
  logic [7:0] operand_b;

  int vectors;
  int miscompares;

  logic [7:0] model [8];

  reg_mem #(
    .DATA_W  (8),
    .ADDR_W  (3),
    .NUM_REGS(8)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .write    (write),
    .opA      (opA),
    .opB      (opB),
    .wR       (wR),
    .dataIn   (dataIn),
    .operand_a(operand_a),
    .operand_b(operand_b)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Safety net so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  // Advance one rising edge and settle just after it; the model follows the
  // same rules at the same edge.
  task automatic tick();
    @(posedge clk);
    if (!reset) begin
      for (int i = 0; i < 8; i++) model[i] = 8'h00;
    end else if (write) begin
      model[wR] = dataIn;
    end
    #1;
  endtask

  task automatic test_reset();
    logic [2:0] pa [4] = '{3'd0, 3'd2, 3'd4, 3'd6};
    write = 1'b0;
    reset = 1'b0;
    tick();
    reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      opA = pa[k];
      opB = pa[k] + 3'd1;
      #1;
      vectors++;
      if (operand_a !== 8'h00) begin
        miscompares++;
        $display("[TB] FAIL reset_a opA=%0d actual=%h required=00", opA, operand_a);
      end
      vectors++;
      if (operand_b !== 8'h00) begin
        miscompares++;
        $display("[TB] FAIL reset_b opB=%0d actual=%h required=00", opB, operand_b);
      end
    end
  endtask

  task automatic test_single_write();
    write  = 1'b1;
    wR     = 3'd3;
    dataIn = 8'h0A;
    tick();
    write = 1'b0;
    opA = 3'd3;
    opB = 3'd3;
    #1;
    vectors++;
    if (operand_a !== 8'h0A) begin
      miscompares++;
      $display("[TB] FAIL single_write_a actual=%h required=0a", operand_a);
    end
    vectors++;
    if (operand_b !== 8'h0A) begin
      miscompares++;
      $display("[TB] FAIL single_write_b actual=%h required=0a", operand_b);
    end
    for (int i = 0; i < 8; i++) begin
      if (i == 3) continue;
      opA = 3'(i);
      opB = 3'(7 - i);
      #1;
      vectors++;
      if (operand_a !== 8'h00) begin
        miscompares++;
        $display("[TB] FAIL single_write_others reg=%0d actual=%h required=00", i, operand_a);
      end
    end
  endtask

  task automatic test_write_all();
    logic [7:0] ea;
    logic [7:0] eb;
    write = 1'b1;
    for (int i = 0; i < 8; i++) begin
      wR     = 3'(i);
      dataIn = 8'h10 + 8'(i);
      tick();
    end
    write = 1'b0;
    for (int i = 0; i < 8; i++) begin
      opA = 3'(i);
      opB = 3'(7 - i);
      ea  = 8'h10 + 8'(i);
      eb  = 8'h17 - 8'(i);
      #1;
      vectors++;
      if (operand_a !== ea) begin
        miscompares++;
        $display("[TB] FAIL write_all_a i=%0d actual=%h required=%h", i, operand_a, ea);
      end
      vectors++;
      if (operand_b !== eb) begin
        miscompares++;
        $display("[TB] FAIL write_all_b i=%0d actual=%h required=%h", i, operand_b, eb);
      end
    end
  endtask

  task automatic test_write_disabled();
    write  = 1'b0;
    wR     = 3'd5;
    dataIn = 8'hFF;
    opA    = 3'd5;
    opB    = 3'd5;
    for (int k = 0; k < 4; k++) begin
      tick();
      vectors++;
      if (operand_a !== 8'h15) begin
        miscompares++;
        $display("[TB] FAIL write_disabled edge=%0d actual=%h required=15", k, operand_a);
      end
    end
  endtask

  task automatic test_reset_priority();
    reset  = 1'b0;
    write  = 1'b1;
    wR     = 3'd2;
    dataIn = 8'hAA;
    tick();
    reset = 1'b1;
    write = 1'b0;
    for (int i = 0; i < 8; i++) begin
      opA = 3'(i);
      opB = 3'(i);
      #1;
      vectors++;
      if (operand_a !== 8'h00 || operand_b !== 8'h00) begin
        miscompares++;
        $display("[TB] FAIL reset_priority reg=%0d actual=%h/%h required=00/00",
                 i, operand_a, operand_b);
      end
    end
  endtask

  task automatic test_read_during_write();
    // Give reg4 a known non-zero old value first.
    write  = 1'b1;
    wR     = 3'd4;
    dataIn = 8'h33;
    tick();
    opA    = 3'd4;
    opB    = 3'd0;
    dataIn = 8'h5C;
    #1;
    vectors++;
    if (operand_a !== 8'h33) begin
      miscompares++;
      $display("[TB] FAIL rdw_before_edge actual=%h required=33", operand_a);
    end
    tick();
    write = 1'b0;
    vectors++;
    if (operand_a !== 8'h5C) begin
      miscompares++;
      $display("[TB] FAIL rdw_after_edge actual=%h required=5c", operand_a);
    end
  endtask

  task automatic test_back_to_back();
    // Consecutive writes to neighbouring registers, reading the one written
    // in the previous cycle while the next write is pending.
    write = 1'b1;
    for (int i = 0; i < 8; i++) begin
      wR     = 3'(i);
      dataIn = 8'hC0 ^ 8'(i * 7);
      opA    = 3'(i);
      opB    = 3'(i - 1);
      #1;
      vectors++;
      if (operand_a !== model[opA] || operand_b !== model[opB]) begin
        miscompares++;
        $display("[TB] FAIL back_to_back i=%0d actual=%h/%h required=%h/%h",
                 i, operand_a, operand_b, model[opA], model[opB]);
      end
      tick();
    end
    write = 1'b0;
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      reset  = ($urandom_range(0, 15) != 0);
      write  = $urandom_range(0, 1) == 1;
      wR     = 3'($urandom_range(0, 7));
      dataIn = 8'($urandom);
      opA    = 3'($urandom_range(0, 7));
      opB    = 3'($urandom_range(0, 7));
      #1;
      vectors++;
      if (operand_a !== model[opA] || operand_b !== model[opB]) begin
        miscompares++;
        $display("[TB] FAIL random_pre n=%0d opA=%0d opB=%0d actual=%h/%h required=%h/%h",
                 n, opA, opB, operand_a, operand_b, model[opA], model[opB]);
      end
      tick();
      vectors++;
      if (operand_a !== model[opA] || operand_b !== model[opB]) begin
        miscompares++;
        $display("[TB] FAIL random_post n=%0d opA=%0d opB=%0d actual=%h/%h required=%h/%h",
                 n, opA, opB, operand_a, operand_b, model[opA], model[opB]);
      end
    end
    reset = 1'b1;
    write = 1'b0;
  endtask

  // Scenario sequence. Inputs change only #1 after a rising edge.
  initial begin
    vectors     = 0;
    miscompares = 0;
    reset  = 1'b1;
    write  = 1'b0;
    opA    = 3'd0;
    opB    = 3'd0;
    wR     = 3'd0;
    dataIn = 8'h00;
    for (int i = 0; i < 8; i++) model[i] = 8'hxx;
    @(posedge clk);
    #1;

    test_reset();
    test_single_write();
    test_write_all();
    test_write_disabled();
    test_reset_priority();
    test_read_during_write();
    test_back_to_back();
    test_random();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
